// File: rtl/race_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// race_game_ctrl : start/run/crash/game-over sequencer with BCD score and HUD
// Rev 1.0
// ============================================================================
module race_game_ctrl #(
  parameter int LIVES       = 3,
  parameter int RESET_TICKS = 4,
  parameter int CRASH_TICKS = 120,
  parameter int SCORE_DIV   = 10,
  parameter int DEB_TICKS   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        start,
  input  logic        collision,
  output logic        game_reset,
  output logic        run,
  output logic        crash_flash,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_CRASH = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int c_max_a = (RESET_TICKS > CRASH_TICKS) ? RESET_TICKS : CRASH_TICKS;
  localparam int c_max_t = (c_max_a > SCORE_DIV) ? c_max_a : SCORE_DIV;
  localparam int c_cnt_w = $clog2(c_max_t + 1);
  localparam int c_deb_w = $clog2(DEB_TICKS + 1);
  localparam logic [c_cnt_w-1:0] c_arm_last   = c_cnt_w'(RESET_TICKS - 1);
  localparam logic [c_cnt_w-1:0] c_crash_last = c_cnt_w'(CRASH_TICKS - 1);
  localparam logic [c_cnt_w-1:0] c_div_last   = c_cnt_w'(SCORE_DIV - 1);
  localparam logic [c_deb_w-1:0] c_deb_last   = c_deb_w'(DEB_TICKS - 1);
  localparam logic [2:0]         c_lives      = 3'(LIVES);

  state_t               r_st;
  logic                 r_start_meta, r_start_sync;
  logic                 r_coll_meta, r_coll_sync;
  logic [c_deb_w-1:0]   r_deb_cnt;
  logic                 r_deb_armed;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_flash_cnt;
  logic                 w_start_ok;

  assign state      = r_st;
  assign w_start_ok = tick & r_start_sync & r_deb_armed & (r_deb_cnt == c_deb_last);

  // Saturating 4-digit BCD increment: 9999 holds, otherwise ripple carry per digit.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = (v != 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_meta <= 1'b0;
      r_start_sync <= 1'b0;
      r_coll_meta  <= 1'b0;
      r_coll_sync  <= 1'b0;
    end else begin
      r_start_meta <= start;
      r_start_sync <= r_start_meta;
      r_coll_meta  <= collision;
      r_coll_sync  <= r_coll_meta;
    end
  end

  // One accept per press: after firing, start must read low on a tick to re-arm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_cnt   <= '0;
      r_deb_armed <= 1'b1;
    end else if (tick) begin
      if (!r_start_sync) begin
        r_deb_cnt   <= '0;
        r_deb_armed <= 1'b1;
      end else if (r_deb_armed) begin
        if (r_deb_cnt == c_deb_last) begin
          r_deb_cnt   <= '0;
          r_deb_armed <= 1'b0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st        <= S_IDLE;
      game_reset  <= 1'b1;
      run         <= 1'b0;
      crash_flash <= 1'b0;
      lives       <= c_lives;
      score       <= 16'h0000;
      hi_score    <= 16'h0000;
      r_cnt       <= '0;
      r_flash_cnt <= 3'd0;
    end else if (tick) begin
      case (r_st)
        S_IDLE, S_OVER: begin
          if (w_start_ok) begin
            r_st  <= S_ARM;
            lives <= c_lives;
            score <= 16'h0000;
            r_cnt <= '0;
          end
        end
        S_ARM: begin
          if (r_cnt == c_arm_last) begin
            r_st       <= S_RUN;
            game_reset <= 1'b0;
            run        <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (r_coll_sync) begin
            r_st        <= S_CRASH;
            run         <= 1'b0;
            crash_flash <= 1'b0;
            r_cnt       <= '0;
            r_flash_cnt <= 3'd0;
            if (lives != 3'd0) lives <= lives - 1'b1;
          end else if (r_cnt == c_div_last) begin
            r_cnt <= '0;
            score <= bcd_inc(score);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CRASH: begin
          if (r_cnt == c_crash_last) begin
            r_cnt       <= '0;
            crash_flash <= 1'b0;
            game_reset  <= 1'b1;
            if (lives != 3'd0) begin
              r_st <= S_ARM;
            end else begin
              r_st <= S_OVER;
              if (score > hi_score) hi_score <= score;
            end
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            r_flash_cnt <= r_flash_cnt + 1'b1;
            if (r_flash_cnt == 3'd7) crash_flash <= ~crash_flash;
          end
        end
        default: begin
          r_st        <= S_IDLE;
          game_reset  <= 1'b1;
          run         <= 1'b0;
          crash_flash <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_race_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_race_game_ctrl : randomized scoreboard bench against a tick-level game model
// Rev 1.0
// ============================================================================
module tb_race_game_ctrl;

  localparam int DEB   = 3;
  localparam int RST_T = 4;
  localparam int CRS_T = 120;
  localparam int NLIV  = 3;

  typedef struct {
    int st;
    int lives;
    int score;
    int hi;
    int cnt;
    int deb;
    bit armed;
  } model_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic collision = 1'b0;

  logic        gr_a, run_a, fl_a, gr_b, run_b, fl_b;
  logic [2:0]  lv_a, st_a, lv_b, st_b;
  logic [15:0] sc_a, hi_a, sc_b, hi_b;

  int n_checks = 0;
  int n_fail   = 0;
  model_t m_a, m_b;
  model_t q_a[$];
  model_t q_b[$];

  always #5 clk = ~clk;

  race_game_ctrl #(.LIVES(NLIV), .RESET_TICKS(RST_T), .CRASH_TICKS(CRS_T),
                   .SCORE_DIV(10), .DEB_TICKS(DEB)) u_dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .collision(collision),
    .game_reset(gr_a), .run(run_a), .crash_flash(fl_a), .lives(lv_a),
    .score(sc_a), .hi_score(hi_a), .state(st_a));

  // Second instance scores every RUN tick so saturation at 9999 is reachable.
  race_game_ctrl #(.LIVES(NLIV), .RESET_TICKS(RST_T), .CRASH_TICKS(CRS_T),
                   .SCORE_DIV(1), .DEB_TICKS(DEB)) u_fast (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .collision(collision),
    .game_reset(gr_b), .run(run_b), .crash_flash(fl_b), .lives(lv_b),
    .score(sc_b), .hi_score(hi_b), .state(st_b));

  function automatic model_t reset_model();
    model_t m;
    m.st = 0; m.lives = NLIV; m.score = 0; m.hi = 0; m.cnt = 0; m.deb = 0; m.armed = 1'b1;
    return m;
  endfunction

  function automatic int to_bcd(int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  // One game tick of the rules: debounce, then the state's behaviour.
  function automatic model_t step(model_t mi, bit s, bit c, int div);
    model_t m;
    bit ok;
    m  = mi;
    ok = 1'b0;
    if (!s) begin
      m.deb = 0; m.armed = 1'b1;
    end else if (m.armed) begin
      m.deb++;
      if (m.deb == DEB) begin ok = 1'b1; m.armed = 1'b0; m.deb = 0; end
    end
    case (m.st)
      0, 4: if (ok) begin m.st = 1; m.lives = NLIV; m.score = 0; m.cnt = 0; end
      1: begin
        m.cnt++;
        if (m.cnt == RST_T) begin m.st = 2; m.cnt = 0; end
      end
      2: begin
        if (c) begin
          m.st = 3; m.cnt = 0;
          if (m.lives > 0) m.lives--;
        end else begin
          m.cnt++;
          if (m.cnt == div) begin
            m.cnt = 0;
            if (m.score < 9999) m.score++;
          end
        end
      end
      3: begin
        m.cnt++;
        if (m.cnt == CRS_T) begin
          m.cnt = 0;
          if (m.lives > 0) m.st = 1;
          else begin
            m.st = 4;
            if (m.score > m.hi) m.hi = m.score;
          end
        end
      end
      default: m.st = 0;
    endcase
    return m;
  endfunction

  task automatic cmp(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_one(string tag, model_t e, logic [2:0] st, logic rn, logic gr,
                           logic fl, logic [2:0] lv, logic [15:0] sc, logic [15:0] hi);
    cmp({tag, ".state"}, int'(st), e.st);
    cmp({tag, ".run"}, int'(rn), (e.st == 2) ? 1 : 0);
    cmp({tag, ".game_reset"}, int'(gr), (e.st == 0 || e.st == 1 || e.st == 4) ? 1 : 0);
    cmp({tag, ".crash_flash"}, int'(fl), (e.st == 3) ? ((e.cnt / 8) % 2) : 0);
    cmp({tag, ".lives"}, int'(lv), e.lives);
    cmp({tag, ".score"}, int'(sc), to_bcd(e.score));
    cmp({tag, ".hi_score"}, int'(hi), to_bcd(e.hi));
  endtask

  // Monitor: every tick edge presents a new response; pop and compare.
  always @(posedge clk) begin
    if (tick && reset_n) begin
      #1;
      if (q_a.size() == 0 || q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_empty actual=0 expected=1 t=%0t", $time);
      end else begin
        check_one("main", q_a.pop_front(), st_a, run_a, gr_a, fl_a, lv_a, sc_a, hi_a);
        check_one("fast", q_b.pop_front(), st_b, run_b, gr_b, fl_b, lv_b, sc_b, hi_b);
      end
    end
  end

  // Called at a negedge; issues one tick and records the expected outcome.
  task automatic tick_cycle();
    m_a = step(m_a, start, collision, 10);
    m_b = step(m_b, start, collision, 1);
    q_a.push_back(m_a);
    q_b.push_back(m_b);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  // Inputs change, synchronisers settle, then n ticks with inputs held.
  task automatic seg(int n, bit s, bit c);
    @(negedge clk);
    start = s;
    collision = c;
    repeat (3) @(negedge clk);
    repeat (n) tick_cycle();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_a = reset_model();
    m_b = reset_model();
    #12;
    check_one("reset_main", reset_model(), st_a, run_a, gr_a, fl_a, lv_a, sc_a, hi_a);
    check_one("reset_fast", reset_model(), st_b, run_b, gr_b, fl_b, lv_b, sc_b, hi_b);
    @(negedge clk);
    reset_n = 1'b1;

    seg(5, 1'b0, 1'b0);
    seg(2, 1'b1, 1'b0);
    seg(3, 1'b0, 1'b0);
    seg(50, 1'b1, 1'b0);
    seg(57, 1'b0, 1'b0);
    cmp("score_after_100_run_ticks", int'(sc_a), 16'h0010);

    seg(1, 1'b0, 1'b1);
    seg(20, 1'b0, 1'b1);
    seg(100, 1'b0, 1'b0);
    seg(10100, 1'b0, 1'b0);
    cmp("fast_saturated", int'(sc_b), 16'h9999);
    seg(1, 1'b0, 1'b1);
    seg(124, 1'b0, 1'b0);
    seg(5, 1'b0, 1'b0);
    seg(1, 1'b0, 1'b1);
    seg(120, 1'b0, 1'b0);
    seg(5, 1'b0, 1'b0);
    cmp("over_hi_equals_score", int'(hi_a), int'(sc_a));

    seg(3, 1'b1, 1'b0);
    seg(10, 1'b0, 1'b0);
    seg(1, 1'b0, 1'b1);
    seg(30, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_one("async_main", reset_model(), st_a, run_a, gr_a, fl_a, lv_a, sc_a, hi_a);
    check_one("async_fast", reset_model(), st_b, run_b, gr_b, fl_b, lv_b, sc_b, hi_b);
    m_a = reset_model();
    m_b = reset_model();
    collision = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 40; i++)
      seg($urandom_range(1, 40), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

    repeat (3) @(negedge clk);
    cmp("queue_drained_main", q_a.size(), 0);
    cmp("queue_drained_fast", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
